// File: rtl/arrow_scheduler.sv
// arrow_scheduler: gameplay sequencer for the 16x16 LED dance game.
// Divides clk into game ticks, scrolls pseudo-random arrows down four lanes,
// judges key presses against the two bottom rows, and tracks score/misses.
// Optional feature macro: SPEEDUP_EN (tick period halves after every 8 hits).
module arrow_scheduler #(
  parameter int unsigned TICK_DIV   = 12500000,
  parameter int unsigned ROWS       = 16,
  parameter int unsigned MAX_MISSES = 5,
  parameter int unsigned SPAWN_GAP  = 3,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
  input  logic                 clk,
  input  logic                 RST,
  input  logic                 start,
  input  logic [3:0]           keys,
  output logic [ROWS-1:0][3:0] arrow_map,
  output logic [7:0]           score,
  output logic [2:0]           miss_cnt,
  output logic                 hit,
  output logic                 miss,
  output logic                 playing,
  output logic                 game_over
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned GW = (SPAWN_GAP > 0) ? $clog2(SPAWN_GAP + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_COUNTDOWN, S_PLAY, S_OVER} state_t;

  state_t               state;
  logic [CW-1:0]        tick_cnt;
  logic [CW-1:0]        tick_last;
  logic [1:0]           cd_ticks;
  logic [GW-1:0]        gap;
  logic [7:0]           lfsr;
  logic                 tick;
  logic                 enter_cd;
  logic                 play_act;
  logic [3:0]           hit_r0;
  logic [3:0]           hit_r1;
  logic [3:0]           lost;
  logic [3:0]           spawn_row;
  logic [2:0]           nhits;
  logic [2:0]           nlost;
  logic [ROWS-1:0][3:0] map_judged;
  logic [ROWS-1:0][3:0] map_shifted;
  logic [3:0]           miss_sum;
  logic [2:0]           miss_next;
  logic [8:0]           score_sum;
  logic [7:0]           score_next;
  logic                 lfsr_fb;

  // Tick decode plus the judgment -> drop -> shift -> spawn datapath
  always_comb begin
    tick     = ((state == S_COUNTDOWN) || (state == S_PLAY)) && (tick_cnt == tick_last);
    enter_cd = (state == S_IDLE) && start;
    play_act = (state == S_PLAY) && start && (miss_cnt < 3'(MAX_MISSES));

    // A key takes the row-0 arrow first, otherwise the row-1 arrow
    hit_r0 = keys & arrow_map[0];
    hit_r1 = keys & ~arrow_map[0] & arrow_map[1];

    // Judged arrows vanish before the shift so they never count as misses
    map_judged    = arrow_map;
    map_judged[0] = arrow_map[0] & ~hit_r0;
    map_judged[1] = arrow_map[1] & ~hit_r1;
    lost          = map_judged[0];

    nhits = '0;
    nlost = '0;
    for (int unsigned l = 0; l < 4; l++) begin
      nhits = nhits + 3'(hit_r0[l] | hit_r1[l]);
      nlost = nlost + 3'(lost[l]);
    end

    spawn_row = '0;
    if ((gap >= GW'(SPAWN_GAP)) && lfsr[0]) spawn_row[lfsr[2:1]] = 1'b1;
    map_shifted = {spawn_row, map_judged[ROWS-1:1]};

    miss_sum   = {1'b0, miss_cnt} + {1'b0, nlost};
    miss_next  = (miss_sum >= 4'(MAX_MISSES)) ? 3'(MAX_MISSES) : miss_sum[2:0];
    score_sum  = {1'b0, score} + {6'b0, nhits};
    score_next = score_sum[8] ? 8'hFF : score_sum[7:0];
    lfsr_fb    = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
  end

  // Game FSM, scroll field, scoring and registered status pulses
  always_ff @(posedge clk) begin
    if (RST) begin
      state     <= S_IDLE;
      arrow_map <= '0;
      score     <= '0;
      miss_cnt  <= '0;
      hit       <= 1'b0;
      miss      <= 1'b0;
      playing   <= 1'b0;
      game_over <= 1'b0;
      tick_cnt  <= '0;
      cd_ticks  <= '0;
      gap       <= '0;
      lfsr      <= LFSR_SEED;
    end else begin
      hit  <= 1'b0;
      miss <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_COUNTDOWN;
            arrow_map <= '0;
            score     <= '0;
            miss_cnt  <= '0;
            lfsr      <= LFSR_SEED;
            gap       <= '0;
            tick_cnt  <= '0;
            cd_ticks  <= '0;
          end
        end
        S_COUNTDOWN: begin
          tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
          if (tick) begin
            if (cd_ticks == 2'd2) begin
              state    <= S_PLAY;
              playing  <= 1'b1;
              cd_ticks <= '0;
            end else begin
              cd_ticks <= cd_ticks + 1'b1;
            end
          end
        end
        S_PLAY: begin
          if (!start) begin
            state     <= S_IDLE;
            playing   <= 1'b0;
            arrow_map <= '0;
            tick_cnt  <= '0;
          end else if (!play_act) begin
            // Miss limit reached on the previous edge: freeze everything
            state     <= S_OVER;
            playing   <= 1'b0;
            game_over <= 1'b1;
            tick_cnt  <= '0;
          end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            score    <= score_next;
            hit      <= |nhits;
            if (tick) begin
              arrow_map <= map_shifted;
              miss_cnt  <= miss_next;
              miss      <= |lost;
              lfsr      <= {lfsr[6:0], lfsr_fb};
              if (|spawn_row)                 gap <= '0;
              else if (gap < GW'(SPAWN_GAP))  gap <= gap + 1'b1;
            end else begin
              arrow_map <= map_judged;
            end
          end
        end
        S_OVER: begin
          if (!start) begin
            state     <= S_IDLE;
            game_over <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SPEEDUP_EN
  localparam int unsigned FLOOR = ((TICK_DIV / 4) > 0) ? (TICK_DIV / 4) : 1;

  logic [CW-1:0] pend_last;
  logic [CW-1:0] halved_last;
  logic [2:0]    hit_mod;
  logic [3:0]    hit_sum;
  logic [31:0]   half_per;

  // Next-shorter tick period, clamped at a quarter of the base period
  always_comb begin
    hit_sum  = {1'b0, hit_mod} + {1'b0, nhits};
    half_per = (32'(pend_last) + 32'd1) >> 1;
    if (half_per < 32'(FLOOR)) half_per = 32'(FLOOR);
    halved_last = CW'(half_per - 32'd1);
  end

  // Pending period is adopted only when the tick counter wraps
  always_ff @(posedge clk) begin
    if (RST || enter_cd) begin
      tick_last <= CW'(TICK_DIV - 1);
      pend_last <= CW'(TICK_DIV - 1);
      hit_mod   <= '0;
    end else begin
      if (play_act) begin
        hit_mod <= hit_sum[2:0];
        if (hit_sum[3]) pend_last <= halved_last;
      end
      if (tick) tick_last <= pend_last;
    end
  end
`else
  assign tick_last = CW'(TICK_DIV - 1);
`endif

endmodule

// File: tb/tb_arrow_scheduler.sv
// tb_arrow_scheduler: directed + randomized bench with a behavioural game model.
module tb_arrow_scheduler;
  localparam int unsigned TD   = 4;
  localparam int unsigned NR   = 16;
  localparam int unsigned MAXM = 5;
  localparam int unsigned GAP  = 3;
  localparam logic [7:0]  SEED = 8'hA5;

  localparam int P_IDLE = 0;
  localparam int P_CD   = 1;
  localparam int P_PLAY = 2;
  localparam int P_OVER = 3;

  logic               clk = 1'b0;
  logic               RST;
  logic               start;
  logic [3:0]         keys;
  logic [NR-1:0][3:0] arrow_map;
  logic [7:0]         score;
  logic [2:0]         miss_cnt;
  logic               hit;
  logic               miss;
  logic               playing;
  logic               game_over;

  arrow_scheduler #(
    .TICK_DIV  (TD),
    .ROWS      (NR),
    .MAX_MISSES(MAXM),
    .SPAWN_GAP (GAP),
    .LFSR_SEED (SEED)
  ) dut (
    .clk      (clk),
    .RST      (RST),
    .start    (start),
    .keys     (keys),
    .arrow_map(arrow_map),
    .score    (score),
    .miss_cnt (miss_cnt),
    .hit      (hit),
    .miss     (miss),
    .playing  (playing),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural game model
  int        ph;
  bit [3:0]  mm [NR];
  int        sc, mc, cnt, cdt, gp;
  bit        mh, mmi;
  logic [7:0] lf;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] map_vec();
    logic [63:0] v;
    v = '0;
    for (int r = 0; r < NR; r++) v[r*4 +: 4] = mm[r];
    return v;
  endfunction

  task automatic clear_map();
    for (int r = 0; r < NR; r++) mm[r] = 4'b0;
  endtask

  // Apply the game rules for one clock edge using the inputs present at it
  task automatic model_edge();
    bit t;
    int nh, nd;
    logic fb;
    mh = 0;
    mmi = 0;
    if (RST) begin
      ph = P_IDLE; clear_map(); sc = 0; mc = 0; cnt = 0; cdt = 0; gp = 0; lf = SEED;
      return;
    end
    case (ph)
      P_IDLE: if (start) begin
        ph = P_CD; clear_map(); sc = 0; mc = 0; lf = SEED; gp = 0; cnt = 0; cdt = 0;
      end
      P_CD: begin
        t = (cnt == TD - 1);
        cnt = t ? 0 : cnt + 1;
        if (t) begin
          cdt++;
          if (cdt == 3) ph = P_PLAY;
        end
      end
      P_PLAY: begin
        if (!start) begin
          ph = P_IDLE; clear_map(); cnt = 0;
        end else if (mc >= MAXM) begin
          ph = P_OVER; cnt = 0;
        end else begin
          t = (cnt == TD - 1);
          cnt = t ? 0 : cnt + 1;
          nh = 0;
          for (int l = 0; l < 4; l++) begin
            if (keys[l]) begin
              if (mm[0][l])      begin mm[0][l] = 1'b0; nh++; end
              else if (mm[1][l]) begin mm[1][l] = 1'b0; nh++; end
            end
          end
          sc = (sc + nh > 255) ? 255 : sc + nh;
          mh = (nh > 0);
          if (t) begin
            nd = $countones(mm[0]);
            mc = (mc + nd > MAXM) ? MAXM : mc + nd;
            mmi = (nd > 0);
            for (int r = 0; r < NR - 1; r++) mm[r] = mm[r+1];
            mm[NR-1] = 4'b0;
            if (gp >= GAP && lf[0]) begin
              mm[NR-1][lf[2:1]] = 1'b1;
              gp = 0;
            end else if (gp < GAP) begin
              gp++;
            end
            fb = ^(lf & 8'hB8);
            lf = {lf[6:0], fb};
          end
        end
      end
      default: if (!start) ph = P_IDLE;
    endcase
  endtask

  // One clock: advance model, then compare every output just after the edge
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("arrow_map", arrow_map, map_vec());
    chk("score", score, sc);
    chk("miss_cnt", miss_cnt, mc);
    chk("hit", hit, mh);
    chk("miss", miss, mmi);
    chk("playing", playing, ph == P_PLAY);
    chk("game_over", game_over, ph == P_OVER);
  endtask

  initial begin
    int n;
    int s0, m0;
    bit found;
    logic [63:0] snap;

    // Reset with start held high
    RST = 1'b1; start = 1'b1; keys = 4'b0;
    step();
    step();
    chk("reset_playing", playing, 1'b0);
    chk("reset_map", arrow_map, 64'd0);

    // Countdown latency after release
    RST = 1'b0;
    n = 0;
    while (!playing && n < 40) begin step(); n++; end
    chk("start_latency", n, 13);

    // Play with no keys until the miss limit ends the game
    n = 0;
    while (!game_over && n < 3000) begin step(); n++; end
    chk("game_over_reached", game_over, 1'b1);
    chk("final_miss_cnt", miss_cnt, MAXM);
    snap = map_vec();
    for (int i = 0; i < 50; i++) begin
      keys = 4'($urandom_range(0, 15));
      step();
      chk("over_frozen_map", arrow_map, snap);
    end
    keys = 4'b0;

    // start=0 back to IDLE, then a fresh game replaying the seed sequence
    start = 1'b0;
    step();
    chk("over_to_idle", game_over, 1'b0);
    start = 1'b1;
    n = 0;
    while (!playing && n < 40) begin step(); n++; end
    chk("restart_latency", n, 13);
    chk("restart_score", score, 8'd0);

    // Lane-2 arrow sitting in row 1, hit by its key (row-0 arrows kept cleared)
    found = 0;
    for (int i = 0; i < 4000 && !found; i++) begin
      if (mm[1][2] && !mm[0][2] && cnt != TD - 1) found = 1;
      else begin keys = mm[0]; step(); keys = 4'b0; end
    end
    chk("lane2_found", found, 1'b1);
    s0 = sc;
    keys = 4'b0100;
    step();
    keys = 4'b0;
    chk("lane2_hit", hit, 1'b1);
    chk("lane2_score", score, s0 + 1);
    chk("lane2_cleared", arrow_map[1][2], 1'b0);

    // Key on an empty lane is ignored without penalty
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      if (!mm[0][0] && !mm[1][0] && cnt != TD - 1) found = 1;
      else begin keys = mm[0]; step(); keys = 4'b0; end
    end
    chk("empty_found", found, 1'b1);
    s0 = sc; m0 = mc; snap = map_vec();
    keys = 4'b0001;
    step();
    keys = 4'b0;
    chk("empty_hit", hit, 1'b0);
    chk("empty_score", score, s0);
    chk("empty_miss_cnt", miss_cnt, m0);
    chk("empty_map", arrow_map, snap);

    // Key for row-0 arrows in the same cycle as a tick
    found = 0;
    for (int i = 0; i < 2000 && !found; i++) begin
      if (mm[0] != 4'b0 && cnt == TD - 1) found = 1;
      else step();
    end
    chk("tick_key_found", found, 1'b1);
    s0 = sc; n = $countones(mm[0]);
    keys = mm[0];
    step();
    keys = 4'b0;
    chk("tick_key_hit", hit, 1'b1);
    chk("tick_key_miss", miss, 1'b0);
    chk("tick_key_score", score, s0 + n);

    // Reset mid-play with score >= 3 and arrows on the field
    found = 0;
    for (int i = 0; i < 4000 && !found; i++) begin
      if (sc >= 3 && map_vec() != 64'd0) found = 1;
      else begin keys = mm[0]; step(); keys = 4'b0; end
    end
    chk("midreset_found", found, 1'b1);
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk("midreset_playing", playing, 1'b0);
    chk("midreset_score", score, 8'd0);
    chk("midreset_map", arrow_map, 64'd0);

    // Randomized play with sparse keys and occasional start drops
    for (int i = 0; i < 2500; i++) begin
      keys  = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      start = ($urandom_range(0, 299) != 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
